// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REG    = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/instruction_memory.sv
// Instruction memory: one synchronous write port (program load), combinational read.
module instruction_memory
  import fetch_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic               clock_i,
  input  logic               wr_en_i,
  input  logic [NB_ADDR-1:0] wr_addr_i,
  input  logic [NB_DATA-1:0] wr_data_i,
  input  logic [NB_ADDR-1:0] rd_addr_i,
  output logic [NB_DATA-1:0] rd_data_o
);

  // Contents are deliberately not reset so a loaded program survives a core reset.
  logic [NB_DATA-1:0] mem_q [2**NB_ADDR];

  always_ff @(posedge clock_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fetch_top.sv
// Fetch stage with IF/ID register, next-PC select and run/halt control.
// Optional FETCH_CYCLE_COUNT_EN adds a saturating RUN-cycle counter output.
module fetch_top
  import fetch_pkg::*;
#(
  parameter int NB_DATA   = 32,
  parameter int NB_ADDR   = 8,
  parameter int NB_PC_SRC = 2
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 enable_i,
  input  logic                 imem_wr_en_i,
  input  logic [NB_ADDR-1:0]   imem_wr_addr_i,
  input  logic [NB_DATA-1:0]   imem_wr_data_i,
  input  logic                 stall_i,
  input  logic                 pc_branch_or_jump_i,
  input  logic [NB_PC_SRC-1:0] pc_src_i,
  input  logic [NB_DATA-1:0]   address_branch_i,
  input  logic [NB_DATA-1:0]   address_jump_i,
  input  logic [NB_DATA-1:0]   address_register_i,
  input  logic                 halt_signal_i,
  output logic [NB_DATA-1:0]   instruction_o,
  output logic [NB_DATA-1:0]   pc_decode_o,
  output logic [NB_DATA-1:0]   pc_o,
`ifdef FETCH_CYCLE_COUNT_EN
  output logic [NB_DATA-1:0]   cycle_count_o,
`endif
  output logic                 running_o,
  output logic                 halted_o
);

  localparam logic [NB_DATA-1:0] NOP = NB_DATA'(NOP_INSTR);

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] pc_q, pc_d;
  logic [NB_DATA-1:0] instr_q, instr_d;
  logic [NB_DATA-1:0] pc_dec_q, pc_dec_d;
  logic [NB_DATA-1:0] pc_plus1, pc_target, imem_rdata;
  logic               adv;

  instruction_memory #(
    .NB_DATA(NB_DATA),
    .NB_ADDR(NB_ADDR)
  ) u_imem (
    .clock_i  (clock_i),
    .wr_en_i  (imem_wr_en_i && (state_q == ST_IDLE)),
    .wr_addr_i(imem_wr_addr_i),
    .wr_data_i(imem_wr_data_i),
    .rd_addr_i(pc_q[NB_ADDR-1:0]),
    .rd_data_o(imem_rdata)
  );

  assign adv      = (state_q == ST_RUN) && enable_i && !stall_i;
  assign pc_plus1 = pc_q + {{(NB_DATA-1){1'b0}}, 1'b1};

  always_comb begin
    pc_target = pc_plus1;
    case (pc_src_i)
      PC_SRC_BRANCH: pc_target = address_branch_i;
      PC_SRC_JUMP:   pc_target = address_jump_i;
      PC_SRC_REG:    pc_target = address_register_i;
      default:       pc_target = pc_plus1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_dec_d = pc_dec_q;
    case (state_q)
      ST_IDLE:   if (start_i) state_d = ST_RUN;
      ST_RUN:    if (adv && halt_signal_i) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
    // Halt has priority over a redirect; a redirect inserts one flush bubble.
    if (adv) begin
      pc_dec_d = pc_plus1;
      if (halt_signal_i) begin
        instr_d = NOP;
      end else if (pc_branch_or_jump_i) begin
        pc_d    = pc_target;
        instr_d = NOP;
      end else begin
        pc_d    = pc_plus1;
        instr_d = imem_rdata;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      instr_q  <= NOP;
      pc_dec_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_dec_q <= pc_dec_d;
    end
  end

`ifdef FETCH_CYCLE_COUNT_EN
  logic [NB_DATA-1:0] cycle_count_q;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      cycle_count_q <= '0;
    end else if ((state_q == ST_RUN) && enable_i && (cycle_count_q != '1)) begin
      cycle_count_q <= cycle_count_q + {{(NB_DATA-1){1'b0}}, 1'b1};
    end
  end

  assign cycle_count_o = cycle_count_q;
`endif

  assign instruction_o = instr_q;
  assign pc_decode_o   = pc_dec_q;
  assign pc_o          = pc_q;
  assign running_o     = (state_q == ST_RUN);
  assign halted_o      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_top.sv
// Scoreboard bench for fetch_top: a behavioural model queues expected outputs per clock.
module tb_fetch_top;

  logic        clock_i, reset_i, start_i, enable_i, imem_wr_en_i, stall_i;
  logic        pc_branch_or_jump_i, halt_signal_i;
  logic [7:0]  imem_wr_addr_i;
  logic [1:0]  pc_src_i;
  logic [31:0] imem_wr_data_i, address_branch_i, address_jump_i, address_register_i;
  logic [31:0] instruction_o, pc_decode_o, pc_o;
  logic        running_o, halted_o;
`ifdef FETCH_CYCLE_COUNT_EN
  logic [31:0] cycle_count_o;
`endif

  fetch_top #(.NB_DATA(32), .NB_ADDR(8), .NB_PC_SRC(2)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .enable_i(enable_i),
    .imem_wr_en_i(imem_wr_en_i), .imem_wr_addr_i(imem_wr_addr_i),
    .imem_wr_data_i(imem_wr_data_i), .stall_i(stall_i),
    .pc_branch_or_jump_i(pc_branch_or_jump_i), .pc_src_i(pc_src_i),
    .address_branch_i(address_branch_i), .address_jump_i(address_jump_i),
    .address_register_i(address_register_i), .halt_signal_i(halt_signal_i),
    .instruction_o(instruction_o), .pc_decode_o(pc_decode_o), .pc_o(pc_o),
`ifdef FETCH_CYCLE_COUNT_EN
    .cycle_count_o(cycle_count_o),
`endif
    .running_o(running_o), .halted_o(halted_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] cnt;
    logic        run;
    logic        halt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_txn    = 0;

  // Reference model state
  logic [31:0] m_mem [256];
  int          m_state;          // 0 idle, 1 run, 2 halted
  logic [31:0] m_pc, m_instr, m_pcd, m_cnt;

  function automatic logic [31:0] wval(input logic [31:0] a);
    return 32'hC0DE_0000 + a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pc = 0; m_instr = 0; m_pcd = 0; m_cnt = 0;
  endtask

  task automatic drive_idle();
    start_i = 0; enable_i = 0; imem_wr_en_i = 0; imem_wr_addr_i = 0; imem_wr_data_i = 0;
    stall_i = 0; pc_branch_or_jump_i = 0; pc_src_i = 0; halt_signal_i = 0;
    address_branch_i = 0; address_jump_i = 0; address_register_i = 0;
  endtask

  // Advance the model with the currently driven inputs, queue the expectation,
  // clock the DUT, then pop and compare.
  task automatic cycle();
    exp_t e;
    logic [31:0] tgt;
    if (m_state == 1 && enable_i && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (m_state == 0) begin
      if (imem_wr_en_i) m_mem[imem_wr_addr_i] = imem_wr_data_i;
      if (start_i) m_state = 1;
    end else if (m_state == 1 && enable_i && !stall_i) begin
      m_pcd = m_pc + 1;
      if (halt_signal_i) begin
        m_state = 2; m_instr = 0;
      end else if (pc_branch_or_jump_i) begin
        case (pc_src_i)
          2'b01:   tgt = address_branch_i;
          2'b10:   tgt = address_jump_i;
          2'b11:   tgt = address_register_i;
          default: tgt = m_pc + 1;
        endcase
        m_instr = 0; m_pc = tgt;
      end else begin
        m_instr = m_mem[m_pc[7:0]]; m_pc = m_pc + 1;
      end
    end
    e.pc = m_pc; e.instr = m_instr; e.pcd = m_pcd; e.cnt = m_cnt;
    e.run = (m_state == 1); e.halt = (m_state == 2);
    sb_q.push_back(e);
    @(posedge clock_i);
    #1;
    e = sb_q.pop_front();
    n_txn++;
    $display("txn %0d: pc=%h instr=%h pcd=%h run=%b halt=%b", n_txn, pc_o, instruction_o,
             pc_decode_o, running_o, halted_o);
    check("pc", pc_o, e.pc);
    check("instr", instruction_o, e.instr);
    check("pc_decode", pc_decode_o, e.pcd);
    check("running", {31'b0, running_o}, {31'b0, e.run});
    check("halted", {31'b0, halted_o}, {31'b0, e.halt});
`ifdef FETCH_CYCLE_COUNT_EN
    check("cycle_count", cycle_count_o, e.cnt);
`endif
  endtask

  // Asynchronous reset from mid-cycle, checked before any clock edge.
  task automatic do_reset();
    reset_i = 0;
    #1;
    model_reset();
    check("rst_pc", pc_o, 32'h0);
    check("rst_instr", instruction_o, 32'h0);
    check("rst_pcd", pc_decode_o, 32'h0);
    check("rst_running", {31'b0, running_o}, 32'h0);
    check("rst_halted", {31'b0, halted_o}, 32'h0);
    @(posedge clock_i);
    #1;
    reset_i = 1;
  endtask

  task automatic start_run();
    drive_idle(); start_i = 1; cycle();
    drive_idle(); enable_i = 1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    drive_idle();
    model_reset();
    reset_i = 0;
    #2;
    do_reset();

    // Program load; the final write shares its cycle with start_i.
    for (int a = 0; a < 10; a++) begin
      drive_idle(); imem_wr_en_i = 1; imem_wr_addr_i = 8'(a); imem_wr_data_i = wval(a); cycle();
    end
    for (int a = 16; a < 20; a++) begin
      drive_idle(); imem_wr_en_i = 1; imem_wr_addr_i = 8'(a); imem_wr_data_i = wval(a); cycle();
    end
    drive_idle(); imem_wr_en_i = 1; imem_wr_addr_i = 8'hFF; imem_wr_data_i = wval(32'hFF);
    start_i = 1; cycle();

    // Sequential fetch; a write attempted in RUN must be ignored.
    drive_idle(); enable_i = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("seq_instr", instruction_o, wval(i));
      check("seq_pcd", pc_decode_o, 32'(i + 1));
    end
    imem_wr_en_i = 1; imem_wr_addr_i = 8'd4; imem_wr_data_i = 32'hDEAD_BEEF;
    cycle();
    imem_wr_en_i = 0;

    // Branch at pc=2 followed by single-step pulses.
    do_reset();
    start_run();
    run(2);
    pc_branch_or_jump_i = 1; pc_src_i = 2'b01; address_branch_i = 32'h10;
    cycle();
    check("br_pc", pc_o, 32'h10);
    check("br_flush", instruction_o, 32'h0);
    pc_branch_or_jump_i = 0; pc_src_i = 0;
    cycle();
    check("br_target", instruction_o, wval(32'h10));
    for (int p = 0; p < 3; p++) begin
      enable_i = 1; cycle();
      enable_i = 0; run(3);
      check("step_pc", pc_o, 32'h12 + 32'(p));
    end

    // Stall at pc=5 with a redirect held alongside it.
    do_reset();
    start_run();
    run(5);
    stall_i = 1; pc_branch_or_jump_i = 1; pc_src_i = 2'b10; address_jump_i = 32'h12;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_pc", pc_o, 32'h5);
      check("stall_instr", instruction_o, wval(4));
    end
    stall_i = 0; pc_branch_or_jump_i = 0; pc_src_i = 0;
    cycle();
    check("resume_pc", pc_o, 32'h6);
    run(1);

    // Halt at pc=7 coinciding with a redirect; halt wins and is terminal.
    halt_signal_i = 1; pc_branch_or_jump_i = 1; pc_src_i = 2'b01; address_branch_i = 32'h3;
    cycle();
    check("halt_pc", pc_o, 32'h7);
    check("halt_instr", instruction_o, 32'h0);
    check("halt_flag", {31'b0, halted_o}, 32'h1);
    drive_idle(); start_i = 1; enable_i = 1;
    run(3);
    check("halted_hold_pc", pc_o, 32'h7);

    // Register target beyond memory depth wraps the read address.
    do_reset();
    start_run();
    pc_branch_or_jump_i = 1; pc_src_i = 2'b11; address_register_i = 32'h1FF;
    cycle();
    check("reg_pc", pc_o, 32'h1FF);
    pc_branch_or_jump_i = 0; pc_src_i = 0;
    cycle();
    check("reg_wrap_instr", instruction_o, wval(32'hFF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
